debug_dump_sequencer: RTL and testbench

Sequences debug read-back from the MIPS pipeline to the UART transmitter. On a one-cycle request it dumps the PC (4 bytes), all 32 general registers (128 bytes) or the first 32 data-memory words (128 bytes), one byte per UART transmission, each gated by the UART `tx_done` handshake. It sits between the debug-unit command decoder and the UART TX core, and owns the register-file and data-memory debug read ports while a dump is active.

---
 rtl/debug_dump_sequencer_pkg.sv | 33 +++
 rtl/debug_dump_sequencer_word_byte_serializer.sv | 40 ++++
 rtl/debug_dump_sequencer.sv | 125 ++++++++++++
 tb/tb_debug_dump_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debug_dump_sequencer_pkg.sv
// Shared debug-unit definitions: dump FSM encoding, dump source codes,
// host command bytes, and the FSM state record exposed for checkers.
package debug_dump_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_NEXT = 3'd4
  } dump_state_t;

  typedef enum logic [1:0] {
    SRC_PC = 2'd0,
    SRC_BR = 2'd1,
    SRC_DM = 2'd2
  } dump_src_t;

  // Host command bytes, decoded by the debug-unit command decoder
  localparam logic [7:0] CMD_WRITE_IM   = 8'd1;
  localparam logic [7:0] CMD_CONTINUOUS = 8'd2;
  localparam logic [7:0] CMD_STEP       = 8'd3;
  localparam logic [7:0] CMD_DUMP_BR    = 8'd4;
  localparam logic [7:0] CMD_DUMP_DM    = 8'd5;
  localparam logic [7:0] CMD_DUMP_PC    = 8'd6;

  // FSM registers grouped so a checker can bind to one signal
  typedef struct packed {
    dump_state_t state;
    dump_src_t   src;
  } fsm_dbg_t;

endpackage

// File: rtl/debug_dump_sequencer_word_byte_serializer.sv
// Holds one captured word and presents it one byte at a time, MSB first.
// Loading a word rewinds the byte index to 0.
module word_byte_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [NB_DATA-1:0] word,
  output logic [NB_BYTE-1:0] byte_out,
  output logic               last_byte
);

  logic [NB_DATA-1:0] word_q;
  logic [1:0]         byte_idx;
  logic [NB_DATA-1:0] shifted;

  // Capture the word on load; step through its bytes on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word_q   <= word;
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Byte 0 is the top byte of the word
  always_comb begin
    shifted   = word_q << (byte_idx * NB_BYTE);
    byte_out  = shifted[NB_DATA-1 -: NB_BYTE];
    last_byte = (byte_idx == 2'd3);
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, register-file or data-memory contents to the UART one byte
// at a time, each byte gated by the UART done handshake.
//
// Handshake: o_tx_start is a one-cycle pulse issued in SEND; o_tx_data is
// valid from that cycle and held until i_tx_done_tick is seen in WAIT.
// i_tx_done_tick is only honoured in WAIT, start requests only in IDLE.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 5,
  parameter int N_WORDS = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start_pc,
  input  logic               i_start_br,
  input  logic               i_start_dm,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_rf_data,
  input  logic [NB_DATA-1:0] i_dm_data,
  input  logic               i_tx_done_tick,
  output logic [NB_ADDR-1:0] o_rf_addr,
  output logic [NB_ADDR-1:0] o_dm_addr,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  fsm_dbg_t           dbg;
  logic [NB_ADDR-1:0] word_idx;
  logic [NB_DATA-1:0] load_word;
  logic               ser_load;
  logic               ser_advance;
  logic               last_byte;
  logic               last_word;

  assign ser_load    = (dbg.state == ST_LOAD);
  assign ser_advance = (dbg.state == ST_NEXT) && !last_byte;
  assign last_word   = (dbg.src == SRC_PC) || (word_idx == NB_ADDR'(N_WORDS - 1));

  // Select the word captured in LOAD; read ports are combinational on the address
  always_comb begin
    case (dbg.src)
      SRC_BR:  load_word = i_rf_data;
      SRC_DM:  load_word = i_dm_data;
      default: load_word = i_pc;
    endcase
  end

  word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk       (i_clock),
    .rst       (i_reset),
    .load      (ser_load),
    .advance   (ser_advance),
    .word      (load_word),
    .byte_out  (o_tx_data),
    .last_byte (last_byte)
  );

  // Dump FSM with registered strobes, busy flag and read addresses
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      dbg.state  <= ST_IDLE;
      dbg.src    <= SRC_PC;
      word_idx   <= '0;
      o_rf_addr  <= '0;
      o_dm_addr  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (dbg.state)
        ST_IDLE: begin
          if (i_start_pc || i_start_br || i_start_dm) begin
            // PC > BR > DM; losing requests are simply dropped
            dbg.src   <= i_start_pc ? SRC_PC : (i_start_br ? SRC_BR : SRC_DM);
            dbg.state <= ST_LOAD;
            word_idx  <= '0;
            o_rf_addr <= '0;
            o_dm_addr <= '0;
            o_busy    <= 1'b1;
          end
        end
        ST_LOAD: begin
          dbg.state  <= ST_SEND;
          o_tx_start <= 1'b1;
        end
        ST_SEND: begin
          dbg.state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done_tick) dbg.state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!last_byte) begin
            dbg.state  <= ST_SEND;
            o_tx_start <= 1'b1;
          end else if (last_word) begin
            dbg.state <= ST_IDLE;
            word_idx  <= '0;
            o_rf_addr <= '0;
            o_dm_addr <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            dbg.state <= ST_LOAD;
            word_idx  <= word_idx + NB_ADDR'(1);
            if (dbg.src == SRC_BR) o_rf_addr <= word_idx + NB_ADDR'(1);
            if (dbg.src == SRC_DM) o_dm_addr <= word_idx + NB_ADDR'(1);
          end
        end
        default: dbg.state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: a table of dump requests with
// bench-side models for the register file, data memory and byte order.
module tb_debug_dump_sequencer;

  localparam logic [1:0] S_PC = 2'd0;
  localparam logic [1:0] S_BR = 2'd1;
  localparam logic [1:0] S_DM = 2'd2;

  typedef struct {
    logic [2:0]  starts;     // {pc, br, dm}
    logic [31:0] pc;
    int          hold;       // cycles in WAIT before tx_done
    int          exp_bytes;
    logic [1:0]  exp_src;
    bit          spurious;   // tx_done pulse while in SEND
    bit          poke_br;    // extra start_br during the first WAIT
  } dump_vec_t;

  logic        clk;
  logic        rst;
  logic        start_pc, start_br, start_dm;
  logic [31:0] pc;
  logic [31:0] rf_data, dm_data;
  logic        tx_done;
  logic [4:0]  rf_addr, dm_addr;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, done;

  logic [7:0]  exp_q[$];
  dump_vec_t   vecs[7];
  int          n_vec;
  int          n_fail;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory models on the debug read ports
  assign rf_data = 32'h1000_0000 + {27'd0, rf_addr};
  assign dm_data = ~{27'd0, dm_addr};

  debug_dump_sequencer dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start_pc     (start_pc),
    .i_start_br     (start_br),
    .i_start_dm     (start_dm),
    .i_pc           (pc),
    .i_rf_data      (rf_data),
    .i_dm_data      (dm_data),
    .i_tx_done_tick (tx_done),
    .o_rf_addr      (rf_addr),
    .o_dm_addr      (dm_addr),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [1:0] src, input logic [31:0] pcv, input int b);
    logic [31:0] w;
    int k;
    k = b / 4;
    case (src)
      S_BR:    w = 32'h1000_0000 + 32'(k);
      S_DM:    w = ~(32'(k));
      default: w = pcv;
    endcase
    w = w >> (24 - 8 * (b % 4));
    return w[7:0];
  endfunction

  task automatic quiet_window(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  // Driver: request a dump and serve every byte, scoring against exp_q
  task automatic run_dump(input int vi, input int abort_after);
    dump_vec_t   v;
    int          lat;
    bit          stable;
    logic [7:0]  held;
    logic [7:0]  exp_b;
    v = vecs[vi];
    exp_q.delete();
    for (int b = 0; b < v.exp_bytes; b++) exp_q.push_back(model_byte(v.exp_src, v.pc, b));
    pc = v.pc;
    @(negedge clk);
    {start_pc, start_br, start_dm} = v.starts;
    @(negedge clk);
    start_pc = 1'b0; start_br = 1'b0; start_dm = 1'b0;
    check($sformatf("v%0d_busy_after_start", vi), 32'(busy), 32'd1);
    check($sformatf("v%0d_no_tx_in_load", vi), 32'(tx_start), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_first_tx_start", vi), 32'(tx_start), 32'd1);
    for (int b = 0; b < v.exp_bytes; b++) begin
      exp_b = exp_q.pop_front();
      check($sformatf("v%0d_byte%0d", vi, b), 32'(tx_data), 32'(exp_b));
      check($sformatf("v%0d_rf_addr%0d", vi, b), 32'(rf_addr), (v.exp_src == S_BR) ? 32'(b / 4) : 32'd0);
      check($sformatf("v%0d_dm_addr%0d", vi, b), 32'(dm_addr), (v.exp_src == S_DM) ? 32'(b / 4) : 32'd0);
      held = tx_data;
      if (v.spurious) tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (v.poke_br && b == 0) start_br = 1'b1;
      stable = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        if (tx_data !== held || tx_start !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        @(negedge clk);
        start_br = 1'b0;
      end
      if (tx_data !== held || tx_start !== 1'b0) stable = 1'b0;
      check($sformatf("v%0d_hold_stable%0d", vi, b), 32'(stable), 32'd1);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (abort_after != 0 && b + 1 == abort_after) begin
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_start", 32'(tx_start), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_tx_data", 32'(tx_data), 32'd0);
        check("abort_rf_addr", 32'(rf_addr), 32'd0);
        check("abort_dm_addr", 32'(dm_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        quiet_window("abort_no_done");
        return;
      end
      lat = 1;
      while (tx_start !== 1'b1 && done !== 1'b1 && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      if (b == v.exp_bytes - 1) begin
        check($sformatf("v%0d_done_latency", vi), 32'(lat), 32'd2);
        check($sformatf("v%0d_done_pulse", vi), 32'(done), 32'd1);
        check($sformatf("v%0d_busy_at_done", vi), 32'(busy), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", vi), 32'(done), 32'd0);
      end else begin
        check($sformatf("v%0d_latency%0d", vi, b), 32'(lat), (b % 4 == 3) ? 32'd3 : 32'd2);
        check($sformatf("v%0d_next_start%0d", vi, b), 32'(tx_start), 32'd1);
      end
    end
    quiet_window($sformatf("v%0d_quiet_after", vi));
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    start_pc = 1'b0; start_br = 1'b0; start_dm = 1'b0;
    pc = 32'd0;
    tx_done = 1'b0;

    vecs[0] = '{3'b100, 32'h0040_00A8,   8,   4, S_PC, 1'b0, 1'b0};
    vecs[1] = '{3'b010, 32'h0000_0000,   1, 128, S_BR, 1'b0, 1'b0};
    vecs[2] = '{3'b001, 32'h0000_0000,   2, 128, S_DM, 1'b0, 1'b0};
    vecs[3] = '{3'b101, 32'h1234_5678,   3,   4, S_PC, 1'b1, 1'b1};
    vecs[4] = '{3'b011, 32'h0000_0000,   1, 128, S_BR, 1'b0, 1'b0};
    vecs[5] = '{3'b111, 32'hDEAD_BEEF,   2,   4, S_PC, 1'b0, 1'b0};
    vecs[6] = '{3'b100, 32'hCAFE_F00D, 500,   4, S_PC, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rf_addr", 32'(rf_addr), 32'd0);
    check("reset_dm_addr", 32'(dm_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Spurious tx_done while idle
    tx_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_done = 1'b0;
    quiet_window("idle_tx_done_ignored");

    for (int i = 0; i < 7; i++) run_dump(i, 0);

    // Reset after byte 37 of a register dump, then a normal PC dump
    run_dump(1, 37);
    run_dump(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
